btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Input-side conditioning for board pushbuttons/switches feeding the counter/LED demos.
//   Synchronises a raw, bouncing, asynchronous input into clk and filters it with a
//   sample-tick FSM. Emits a clean level plus one-cycle rise/fall pulses that can
//   enable or step counters in place of a divided clock.
// PARAMETERS
//   N            20  width of free-running sample-tick counter; tick period = 2^N clk
//                    (100 MHz, N=20 -> ~10.5 ms)
//   STABLE_TICKS 3   consecutive sample ticks input must hold before output changes (>=1)
// PORTS
//   clk           in   1  system clock (100 MHz)
//   reset         in   1  asynchronous, active-high reset
//   sw            in   1  raw button/switch input, asynchronous to clk, bouncing
//   db_level      out  1  debounced level, registered
//   db_rise_tick  out  1  one-clk pulse on debounced 0->1, registered
//   db_fall_tick  out  1  one-clk pulse on debounced 1->0, registered
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops=0, tick counter q=0, wait cnt=0,
//     state=ZERO, db_level=0, db_rise_tick=0, db_fall_tick=0.
//   Synchroniser: 2-flop chain sw -> s1 -> sw_sync; FSM uses only sw_sync (2-clk latency).
//   Tick gen: q increments every clk, wraps 2^N-1 -> 0; m_tick = (q == 2^N-1), 1 clk wide.
//   Wait counter cnt: width clog2(STABLE_TICKS) (min 1 bit); loaded to 0 on WAIT entry.
//   FSM states (all transitions on posedge clk):
//     ZERO : sw_sync=1 -> WAIT1, cnt<=0; else stay.
//     WAIT1: sw_sync=0 -> ZERO (abort, no pulse). Else on m_tick: cnt==STABLE_TICKS-1 ->
//            ONE, else cnt<=cnt+1. Abort has priority over m_tick in the same cycle.
//     ONE  : sw_sync=0 -> WAIT0, cnt<=0; else stay.
//     WAIT0: sw_sync=1 -> ONE (abort, no pulse). Else on m_tick: cnt==STABLE_TICKS-1 ->
//            ZERO, else cnt<=cnt+1. Abort has priority over m_tick.
//   Outputs registered on the same edge as the state update:
//     db_level = 1 while next state in {ONE, WAIT0}, else 0.
//     db_rise_tick = 1 for exactly the one cycle following the WAIT1->ONE edge; else 0.
//     db_fall_tick = 1 for exactly the one cycle following the WAIT0->ZERO edge; else 0.
//     Rise and fall never assert together; abort paths never pulse.
//   Latency: from first clk where sw_sync is stable, output changes after
//     (STABLE_TICKS-1)*2^N+1 .. STABLE_TICKS*2^N clks (tick phase unaligned), +2 for sync.
//   Tick counter is free-running and never reset by FSM; only reset clears it.
//   Reset mid-operation: immediately forces all outputs 0 and state ZERO; a held-high
//     sw after release requires full debounce before db_level rises.
//   STABLE_TICKS=1: first m_tick with input stable completes the transition.
// TESTING (sim with N=4 -> 16-clk tick, STABLE_TICKS=3; window 33..48 clk + 2 sync)
//   1 reset asserted mid-clock, sw=1 -> all outputs 0 at once; hold 10 clk, still 0.
//   2 release reset, sw 0->1 held 100 clk -> db_level rises 35..50 clk after sw edge;
//     db_rise_tick high exactly 1 clk, coincident with db_level first high; no fall.
//   3 sw toggles every 5 clk for 60 clk, then held 1 -> no pulse/level change during
//     bounce; exactly one db_rise_tick within 35..50 clk of final edge.
//   4 in ZERO, 1-clk sw glitch high, else 0 for 100 clk -> db_level 0, no pulses.
//   5 from ONE, sw->0 held 100 clk -> db_fall_tick one 1-clk pulse, db_level 0 within
//     35..50 clk; 3-clk low glitch from ONE -> stays ONE, no pulse.
//   6 in WAIT1 after 2 ticks, pulse reset 1 clk, sw held 1 -> outputs 0; db_level rises
//     only after a fresh 35..50 clk window, single db_rise_tick.

Source files
------------

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser feeding a sample-tick debounce FSM.
// Produces a registered clean level plus one-clock rise/fall pulses.
module btn_debounce #(
    parameter int unsigned N            = 20,
    parameter int unsigned STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_rise_tick,
    output logic db_fall_tick
);
    localparam int unsigned CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CW-1:0] CntLast = CW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {StZero, StWait1, StOne, StWait0} state_t;

    logic          r_s1;
    logic          r_sw_sync;
    logic [N-1:0]  r_q;
    logic          w_m_tick;
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_level_next;
    logic          w_rise_next;
    logic          w_fall_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_sw_sync <= 1'b0;
        end else begin
            r_s1      <= sw;
            r_sw_sync <= r_s1;
        end
    end

    // Free-running; the FSM never restarts it, so tick phase is unaligned to input edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + N'(1);
        end
    end

    assign w_m_tick = &r_q;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StZero: begin
                if (r_sw_sync) begin
                    w_state_next = StWait1;
                    w_cnt_next   = '0;
                end
            end
            StWait1: begin
                if (!r_sw_sync) begin
                    w_state_next = StZero;
                end else if (w_m_tick) begin
                    if (r_cnt == CntLast) begin
                        w_state_next = StOne;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            StOne: begin
                if (!r_sw_sync) begin
                    w_state_next = StWait0;
                    w_cnt_next   = '0;
                end
            end
            StWait0: begin
                if (r_sw_sync) begin
                    w_state_next = StOne;
                end else if (w_m_tick) begin
                    if (r_cnt == CntLast) begin
                        w_state_next = StZero;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = StZero;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Level follows the committed side: WAIT0 still reports 1 until the fall completes.
    assign w_level_next = (w_state_next == StOne) || (w_state_next == StWait0);
    assign w_rise_next  = (r_state == StWait1) && (w_state_next == StOne);
    assign w_fall_next  = (r_state == StWait0) && (w_state_next == StZero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StZero;
            r_cnt        <= '0;
            db_level     <= 1'b0;
            db_rise_tick <= 1'b0;
            db_fall_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            db_level     <= w_level_next;
            db_rise_tick <= w_rise_next;
            db_fall_tick <= w_fall_next;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bounce, checked per cycle against
// a streak-and-tick reference model through an expected-output queue.
module tb_btn_debounce;
    localparam int unsigned N  = 4;
    localparam int unsigned ST = 3;
    localparam int unsigned TP = 1 << N;

    logic clk = 1'b0;
    logic reset;
    logic sw;
    logic db_level;
    logic db_rise_tick;
    logic db_fall_tick;

    always #5 clk = ~clk;

    btn_debounce #(
        .N            (N),
        .STABLE_TICKS (ST)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .db_level     (db_level),
        .db_rise_tick (db_rise_tick),
        .db_fall_tick (db_fall_tick)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0] exp_q[$];
    bit         sw_hist[$];

    // Reference model: the level flips once the synchronised input has differed from it
    // continuously and ST sample ticks have passed after the first differing edge.
    bit m_level;
    int m_streak;
    int m_ticks;
    int m_n;

    int rise_cnt = 0;
    int fall_cnt = 0;
    int last_rise_cyc = 0;
    int last_fall_cyc = 0;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got={lvl,rise,fall}=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic model_clear();
        m_level  = 1'b0;
        m_streak = 0;
        m_ticks  = 0;
        m_n      = 0;
        sw_hist.delete();
        exp_q.delete();
    endtask

    task automatic model_edge(input bit v);
        bit s;
        bit tick;
        bit rise;
        bit fall;
        s    = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 1'b0;
        sw_hist.push_back(v);
        if (sw_hist.size() > 2) void'(sw_hist.pop_front());
        tick = ((m_n % TP) == TP - 1);
        m_n++;
        rise = 1'b0;
        fall = 1'b0;
        if (s != m_level) begin
            m_streak++;
            if (m_streak > 1 && tick) m_ticks++;
            if (m_ticks == ST) begin
                m_level  = s;
                rise     = s;
                fall     = !s;
                m_streak = 0;
                m_ticks  = 0;
            end
        end else begin
            m_streak = 0;
            m_ticks  = 0;
        end
        exp_q.push_back({m_level, rise, fall});
    endtask

    // Called 1 time unit after a posedge; returns 1 time unit after the next one.
    task automatic step(input bit v);
        sw = v;
        @(posedge clk);
        cyc++;
        if (!reset) model_edge(v);
        #1;
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset(input int n, input bit v);
        #2;
        reset = 1'b1;
        sw    = v;
        model_clear();
        #1;
        check("reset_async", {db_level, db_rise_tick, db_fall_tick}, 3'b000);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("reset_outputs", {db_level, db_rise_tick, db_fall_tick}, 3'b000);
        end else if (reset === 1'b0) begin
            if (db_rise_tick === 1'b1) begin
                rise_cnt++;
                last_rise_cyc = cyc;
            end
            if (db_fall_tick === 1'b1) begin
                fall_cnt++;
                last_fall_cyc = cyc;
            end
            if (exp_q.size() > 0) begin
                check("outputs", {db_level, db_rise_tick, db_fall_tick}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int c0;
        int r0;
        int f0;
        reset = 1'b1;
        sw    = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3, 1'b0);

        // Clean rise.
        hold(0, 10);
        c0 = cyc; r0 = rise_cnt; f0 = fall_cnt;
        hold(1, 100);
        check_int("rise_count_clean", rise_cnt - r0, 1);
        check_int("no_fall_on_rise", fall_cnt - f0, 0);
        check_range("rise_latency_clean", last_rise_cyc - (c0 + 1), 35, 50);

        // Mid-clock reset with sw high clears outputs at once and holds them low.
        do_reset(10, 1'b1);
        hold(0, 60);

        // Bounce then settle high.
        r0 = rise_cnt; f0 = fall_cnt;
        for (int k = 0; k < 12; k++) hold(((k % 2) == 0), 5);
        check_int("bounce_no_rise", rise_cnt - r0, 0);
        check_int("bounce_no_fall", fall_cnt - f0, 0);
        c0 = cyc;
        hold(1, 100);
        check_int("rise_count_bounce", rise_cnt - r0, 1);
        check_range("rise_latency_bounce", last_rise_cyc - (c0 + 1), 35, 50);

        // Clean fall, then a short low glitch from ONE.
        c0 = cyc; f0 = fall_cnt; r0 = rise_cnt;
        hold(0, 100);
        check_int("fall_count_clean", fall_cnt - f0, 1);
        check_range("fall_latency_clean", last_fall_cyc - (c0 + 1), 35, 50);
        hold(1, 100);
        r0 = rise_cnt; f0 = fall_cnt;
        hold(0, 3);
        hold(1, 100);
        check_int("low_glitch_no_fall", fall_cnt - f0, 0);
        check_int("low_glitch_no_rise", rise_cnt - r0, 0);
        check_int("low_glitch_level", int'(db_level), 1);

        // High glitch from ZERO.
        hold(0, 100);
        r0 = rise_cnt; f0 = fall_cnt;
        hold(1, 1);
        hold(0, 100);
        check_int("high_glitch_no_rise", rise_cnt - r0, 0);
        check_int("high_glitch_level", int'(db_level), 0);

        // Reset while part way through WAIT1; a fresh full debounce must follow.
        r0 = rise_cnt;
        hold(1, 34);
        check_int("wait1_no_rise_yet", rise_cnt - r0, 0);
        do_reset(1, 1'b1);
        c0 = cyc;
        hold(1, 100);
        check_int("rise_after_reset", rise_cnt - r0, 1);
        check_range("rise_latency_after_reset", last_rise_cyc - (c0 + 1), 35, 50);

        // Random bursts and holds, with occasional resets.
        for (int k = 0; k < 40; k++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 90))
                                              : int'($urandom_range(1, 20));
            if ($urandom_range(0, 15) == 0) do_reset(int'($urandom_range(1, 3)), v);
            hold(v, len);
        end
        hold(0, 2);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
